// File: rtl/gpu_cmd_parser_pkg.sv
// Shared constants, state encoding and helpers for the GPU command parser.
package gpu_cmd_parser_pkg;

    localparam int NUM_REGS = 12;

    localparam logic [7:0] OP_WRITE = 8'hA5;
    localparam logic [7:0] OP_READ  = 8'h5A;
    localparam logic [7:0] RSP_ACK  = 8'hAA;
    localparam logic [7:0] RSP_NAK  = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_ISSUE,
        S_WAIT_RDY,
        S_SEND
    } state_t;

    // Unsigned compare: 8'hFF is simply out of range.
    function automatic logic addr_ok(input logic [7:0] a);
        return {24'h0, a} < 32'(NUM_REGS);
    endfunction

endpackage

// File: rtl/gpu_cmd_parser_if.sv
// Host byte streams and register-file bus seen by the command parser.
interface gpu_cmd_parser_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_read;
    logic       reg_write;
    logic [7:0] reg_rdata;
    logic       reg_rdy;

    modport master (
        input  rx_data, rx_valid, tx_ready, reg_rdata, reg_rdy,
        output rx_ready, tx_data, tx_valid,
        output reg_addr, reg_wdata, reg_read, reg_write
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, reg_rdata, reg_rdy,
        input  rx_ready, tx_data, tx_valid,
        input  reg_addr, reg_wdata, reg_read, reg_write
    );

endinterface

// File: rtl/gpu_cmd_parser_timeout.sv
// Inter-byte timeout: loadable down-counter, expires after TIMEOUT enabled cycles.
module cmd_timeout #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);

    if (TIMEOUT == 0) begin : g_off
        logic unused;
        assign unused  = ^{clk, rst, clear, en};
        assign expired = 1'b0;
    end else begin : g_on
        localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
        localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

        logic [W-1:0] cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (clear) begin
                cnt <= LOAD;
            end else if (en && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end

        assign expired = en && (cnt == '0);
    end

endmodule

// File: rtl/gpu_cmd_parser.sv
// Host command front end: decodes write/read byte commands into
// register-file strobes and returns one response byte per command.
module gpu_cmd_parser
    import gpu_cmd_parser_pkg::*;
#(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst,
    gpu_cmd_parser_if.master bus
);

    state_t state;
    logic   is_read;
    logic   accept;
    logic   tmo;

    assign accept = bus.rx_valid && bus.rx_ready;

    cmd_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .en      (state == S_GET_ADDR || state == S_GET_DATA),
        .expired (tmo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            is_read       <= 1'b0;
            bus.rx_ready  <= 1'b0;
            bus.tx_valid  <= 1'b0;
            bus.tx_data   <= 8'h00;
            bus.reg_addr  <= 8'h00;
            bus.reg_wdata <= 8'h00;
            bus.reg_read  <= 1'b0;
            bus.reg_write <= 1'b0;
        end else begin
            bus.reg_read  <= 1'b0;
            bus.reg_write <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    bus.rx_ready <= 1'b1;
                    if (accept) begin
                        if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
                            is_read <= (bus.rx_data == OP_READ);
                            state   <= S_GET_ADDR;
                        end else begin
                            bus.tx_data  <= RSP_NAK;
                            bus.tx_valid <= 1'b1;
                            bus.rx_ready <= 1'b0;
                            state        <= S_SEND;
                        end
                    end
                end
                S_GET_ADDR: begin
                    if (accept) begin
                        bus.reg_addr <= bus.rx_data;
                        if (!is_read) begin
                            // Data byte is consumed even when the address is bad.
                            state <= S_GET_DATA;
                        end else if (addr_ok(bus.rx_data)) begin
                            bus.reg_read <= 1'b1;
                            bus.rx_ready <= 1'b0;
                            state        <= S_ISSUE;
                        end else begin
                            bus.tx_data  <= RSP_NAK;
                            bus.tx_valid <= 1'b1;
                            bus.rx_ready <= 1'b0;
                            state        <= S_SEND;
                        end
                    end else if (tmo) begin
                        state <= S_IDLE;
                    end
                end
                S_GET_DATA: begin
                    if (accept) begin
                        bus.reg_wdata <= bus.rx_data;
                        bus.rx_ready  <= 1'b0;
                        if (addr_ok(bus.reg_addr)) begin
                            bus.reg_write <= 1'b1;
                            state         <= S_ISSUE;
                        end else begin
                            bus.tx_data  <= RSP_NAK;
                            bus.tx_valid <= 1'b1;
                            state        <= S_SEND;
                        end
                    end else if (tmo) begin
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (bus.reg_rdy) begin
                        bus.tx_data  <= is_read ? bus.reg_rdata : RSP_ACK;
                        bus.tx_valid <= 1'b1;
                        state        <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.tx_ready) begin
                        bus.tx_valid <= 1'b0;
                        bus.rx_ready <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpu_cmd_parser.sv
// Directed bench for gpu_cmd_parser with a 12-entry register-file model.
module tb_gpu_cmd_parser;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    gpu_cmd_parser_if bus();

    gpu_cmd_parser #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] regs [0:11] = '{default: 8'h00};
    int cyc  = 0;
    int wcnt = 0;
    int rcnt = 0;
    int both = 0;
    logic [7:0] w_addr = 8'h00;
    logic [7:0] w_data = 8'h00;
    logic [7:0] r_addr = 8'h00;

    int tests = 0;
    int fails = 0;
    int acc_cyc = 0;
    int rsp_cyc = 0;

    assign bus.reg_rdata = (bus.reg_addr < 8'd12) ? regs[bus.reg_addr[3:0]] : 8'h00;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bus.reg_write) begin
                if (bus.reg_addr < 8'd12) regs[bus.reg_addr[3:0]] <= bus.reg_wdata;
                wcnt   <= wcnt + 1;
                w_addr <= bus.reg_addr;
                w_data <= bus.reg_wdata;
            end
            if (bus.reg_read) begin
                rcnt   <= rcnt + 1;
                r_addr <= bus.reg_addr;
            end
            if (bus.reg_write && bus.reg_read) both <= both + 1;
        end
    end

    typedef struct {
        int         n;
        logic [7:0] b0, b1, b2;
        logic [7:0] tx;
        int         dw, dr;
        logic [7:0] addr, data;
        int         lat;
    } vec_t;

    vec_t v [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (!bus.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rx_accept_bound", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic get_rsp(output logic [7:0] d);
        int n = 0;
        while (!bus.tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", 32'(bus.tx_valid), 32'd1);
        d = bus.tx_data;
        rsp_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       ok;
        int         w0, r0;

        v[0] = '{3, 8'hA5, 8'h03, 8'h7C, 8'hAA, 1, 0, 8'h03, 8'h7C, 2};
        v[1] = '{2, 8'h5A, 8'h03, 8'h00, 8'h7C, 0, 1, 8'h03, 8'h00, 2};
        v[2] = '{3, 8'hA5, 8'h0C, 8'h11, 8'hEE, 0, 0, 8'h00, 8'h00, 0};
        v[3] = '{2, 8'h5A, 8'hFF, 8'h00, 8'hEE, 0, 0, 8'h00, 8'h00, 0};
        v[4] = '{1, 8'h33, 8'h00, 8'h00, 8'hEE, 0, 0, 8'h00, 8'h00, 0};
        v[5] = '{2, 8'h5A, 8'h00, 8'h00, 8'h00, 0, 1, 8'h00, 8'h00, 2};
        v[6] = '{3, 8'hA5, 8'h0B, 8'hFF, 8'hAA, 1, 0, 8'h0B, 8'hFF, 2};
        v[7] = '{2, 8'h5A, 8'h0B, 8'h00, 8'hFF, 0, 1, 8'h0B, 8'h00, 2};
        v[8] = '{2, 8'h5A, 8'h0C, 8'h00, 8'hEE, 0, 0, 8'h00, 8'h00, 0};

        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        bus.reg_rdy  = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_strobes", 32'({bus.reg_read, bus.reg_write}), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
        chk("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rx_ready", 32'(bus.rx_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            w0 = wcnt;
            r0 = rcnt;
            send_byte(v[i].b0);
            if (v[i].n > 1) send_byte(v[i].b1);
            if (v[i].n > 2) send_byte(v[i].b2);
            get_rsp(d);
            chk($sformatf("vec%0d_tx", i), 32'(d), 32'(v[i].tx));
            chk($sformatf("vec%0d_latency", i), 32'(rsp_cyc - acc_cyc), 32'(v[i].lat));
            chk($sformatf("vec%0d_writes", i), 32'(wcnt - w0), 32'(v[i].dw));
            chk($sformatf("vec%0d_reads", i), 32'(rcnt - r0), 32'(v[i].dr));
            if (v[i].dw == 1) begin
                chk($sformatf("vec%0d_waddr", i), 32'(w_addr), 32'(v[i].addr));
                chk($sformatf("vec%0d_wdata", i), 32'(w_data), 32'(v[i].data));
            end
            if (v[i].dr == 1) chk($sformatf("vec%0d_raddr", i), 32'(r_addr), 32'(v[i].addr));
        end

        // TX backpressure: response held and stable, no input accepted.
        bus.tx_ready = 1'b0;
        send_byte(8'h5A);
        send_byte(8'h03);
        for (int n = 0; n < 100 && !bus.tx_valid; n++) @(negedge clk);
        chk("bp_valid", 32'(bus.tx_valid), 32'd1);
        d  = bus.tx_data;
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus.tx_valid || bus.tx_data !== d || bus.rx_ready) ok = 1'b0;
        end
        chk("bp_hold", 32'(ok), 32'd1);
        chk("bp_data", 32'(d), 32'h7C);
        bus.tx_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", 32'(bus.tx_valid), 32'd0);
        chk("bp_release_rx_ready", 32'(bus.rx_ready), 32'd1);

        // reg_rdy low for five sampling cycles delays the response by five.
        bus.reg_rdy = 1'b0;
        send_byte(8'h5A);
        send_byte(8'h0B);
        ok = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.tx_valid) ok = 1'b0;
        end
        chk("rdy_wait_quiet", 32'(ok), 32'd1);
        bus.reg_rdy = 1'b1;
        get_rsp(d);
        chk("rdy_wait_data", 32'(d), 32'hFF);
        chk("rdy_wait_latency", 32'(rsp_cyc - acc_cyc), 32'd7);

        // Byte arriving in the expiry cycle keeps the command alive.
        w0 = wcnt;
        send_byte(8'hA5);
        repeat (15) @(negedge clk);
        send_byte(8'h04);
        send_byte(8'h99);
        get_rsp(d);
        chk("tmo_edge_tx", 32'(d), 32'hAA);
        chk("tmo_edge_writes", 32'(wcnt - w0), 32'd1);
        chk("tmo_edge_waddr", 32'(w_addr), 32'h04);

        // Sixteen idle cycles abandon the command silently.
        w0 = wcnt;
        send_byte(8'hA5);
        ok = 1'b1;
        repeat (16) begin
            @(negedge clk);
            if (bus.tx_valid) ok = 1'b0;
        end
        chk("tmo_silent", 32'(ok), 32'd1);
        send_byte(8'h5A);
        send_byte(8'h04);
        get_rsp(d);
        chk("tmo_next_cmd", 32'(d), 32'h99);
        chk("tmo_no_write", 32'(wcnt - w0), 32'd0);

        // Reset in WAIT_RDY clears outputs immediately; nothing replays later.
        bus.reg_rdy = 1'b0;
        w0 = wcnt;
        send_byte(8'hA5);
        send_byte(8'h05);
        send_byte(8'h3C);
        @(negedge clk);
        chk("rst_mid_strobe", 32'(wcnt - w0), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs",
            32'({bus.rx_ready, bus.tx_valid, bus.reg_read, bus.reg_write,
                 bus.tx_data, bus.reg_addr, bus.reg_wdata}), 32'd0);
        bus.reg_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.tx_valid) ok = 1'b0;
        end
        chk("rst_mid_no_rsp", 32'(ok), 32'd1);
        chk("rst_mid_no_replay", 32'(wcnt - w0), 32'd1);
        send_byte(8'h5A);
        send_byte(8'h05);
        get_rsp(d);
        chk("rst_mid_readback", 32'(d), 32'h3C);

        chk("never_both_strobes", 32'(both), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
